// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared FSM encoding, default IO addresses and port indices
package mem_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_IO   = 2'd2
  } state_e;

  localparam logic [7:0] DEF_LED_ADDR = 8'hF0;
  localparam logic [7:0] DEF_SW_ADDR  = 8'hF8;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/mem_io_arbiter_sw_sync.sv
// rtl/mem_io_arbiter_sw_sync.sv - switch synchroniser with optional debounce (SW_DEBOUNCE_EN)
module sw_sync #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEB_CYC = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] sw_value_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  if (DEB_CYC < 1) begin : g_deb_chk
    $error("DEB_CYC must be at least 1");
  end

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic [W-1:0]  last_q;
  logic [W-1:0]  val_q;
  logic [CW-1:0] cnt_q;

  // Accept the synchronised value only once it has held still for DEB_CYC cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= '0;
      val_q  <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= sync_q;
      if (sync_q != last_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CW'(DEB_CYC)) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (cnt_q == CW'(DEB_CYC)) begin
        val_q <= last_q;
      end
    end
  end

  assign sw_value_o = val_q;
`else
  assign sw_value_o = sync_q;
`endif

endmodule

// File: rtl/mem_io_arbiter.sv
// rtl/mem_io_arbiter.sv - round-robin memory/LED/switch arbiter; SW_DEBOUNCE_EN enables switch debounce
module mem_io_arbiter
  import mem_io_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(DEF_LED_ADDR),
  parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(DEF_SW_ADDR),
  parameter int unsigned       DEB_CYC  = 16
) (
  input  logic              t_clk,
  input  logic              t_rst_n,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic [1:0]        o_gnt,
  output logic [1:0]        o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [7:0]        t_sw,
  output logic [7:0]        o_leds
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1) begin : g_lat_chk
    $error("MEM_LAT must be at least 1");
  end

  state_e             state_q;
  logic               rr_q;
  logic               port_q;
  logic               mem_rd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         rvalid_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               mem_en_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [7:0]         leds_q;
  logic [7:0]         sw_value;

  logic               gnt_port;
  logic [1:0]         gnt;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  logic               sel_led;
  logic               sel_sw;

  sw_sync #(
    .W       (8),
    .DEB_CYC (DEB_CYC)
  ) u_sw_sync (
    .clk_i      (t_clk),
    .rst_ni     (t_rst_n),
    .sw_i       (t_sw),
    .sw_value_o (sw_value)
  );

  // Round-robin pick: on contention the port that did not win last time goes
  always_comb begin
    gnt      = 2'b00;
    gnt_port = P_CPU;
    if (state_q == ST_IDLE && i_req != 2'b00) begin
      if (i_req == 2'b11) begin
        gnt_port = ~rr_q;
      end else if (i_req[P_DBG]) begin
        gnt_port = P_DBG;
      end else begin
        gnt_port = P_CPU;
      end
      gnt[gnt_port] = 1'b1;
    end
  end

  // Steer the winning port's request and decode its target
  always_comb begin
    sel_addr  = (gnt_port == P_DBG) ? i_addr1  : i_addr0;
    sel_wdata = (gnt_port == P_DBG) ? i_wdata1 : i_wdata0;
    sel_we    = i_we[gnt_port];
    sel_led   = (sel_addr == LED_ADDR);
    sel_sw    = (sel_addr == SW_ADDR);
  end

  // Transaction FSM: grant capture, memory strobe, latency count and IO completion
  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= P_DBG;
      port_q      <= P_CPU;
      mem_rd_q    <= 1'b0;
      cnt_q       <= '0;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      leds_q      <= 8'h00;
    end else begin
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            rr_q   <= gnt_port;
            port_q <= gnt_port;
            if (sel_led || sel_sw) begin
              // IO targets answer immediately; the IO state only blocks the next grant
              state_q            <= ST_IO;
              mem_rd_q           <= 1'b0;
              rvalid_q[gnt_port] <= 1'b1;
              if (sel_we) begin
                if (sel_led) begin
                  leds_q <= sel_wdata[7:0];
                end
              end else if (sel_led) begin
                rdata_q <= {{(DATA_W-8){1'b0}}, leds_q};
              end else begin
                rdata_q <= {{(DATA_W-8){1'b0}}, sw_value};
              end
            end else begin
              state_q     <= ST_MEM;
              mem_rd_q    <= ~sel_we;
              cnt_q       <= CNT_W'(MEM_LAT);
              mem_en_q    <= 1'b1;
              mem_we_q    <= sel_we;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end
          end
        end
        ST_MEM: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q          <= ST_IDLE;
            rvalid_q[port_q] <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_IO: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory read data is passed straight through in its completion cycle
  always_comb begin
    o_rdata = rdata_q;
    if (mem_rd_q && rvalid_q != 2'b00) begin
      o_rdata = i_mem_rdata;
    end
  end

  assign o_gnt       = gnt;
  assign o_rvalid    = rvalid_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_leds      = leds_q;

endmodule

// File: tb/tb_mem_io_arbiter.sv
// tb/tb_mem_io_arbiter.sv - self-checking bench for mem_io_arbiter
module tb_mem_io_arbiter;

  localparam int unsigned MEM_LAT = 1;
  localparam int unsigned DEB_CYC = 4;
  localparam logic [7:0]  LED_A   = 8'hF0;
  localparam logic [7:0]  SW_A    = 8'hF8;

  logic        t_clk = 1'b0;
  logic        t_rst_n = 1'b1;
  logic [1:0]  i_req = 2'b00;
  logic [1:0]  i_we = 2'b00;
  logic [7:0]  i_addr0 = 8'h00;
  logic [7:0]  i_addr1 = 8'h00;
  logic [63:0] i_wdata0 = '0;
  logic [63:0] i_wdata1 = '0;
  logic [63:0] i_mem_rdata = '0;
  logic [7:0]  t_sw = 8'h00;
  logic [1:0]  o_gnt;
  logic [1:0]  o_rvalid;
  logic [63:0] o_rdata;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_leds;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  mem_io_arbiter #(
    .ADDR_W (8), .DATA_W (64), .MEM_LAT (MEM_LAT),
    .LED_ADDR (LED_A), .SW_ADDR (SW_A), .DEB_CYC (DEB_CYC)
  ) dut (
    .t_clk (t_clk), .t_rst_n (t_rst_n), .i_req (i_req), .i_we (i_we),
    .i_addr0 (i_addr0), .i_addr1 (i_addr1), .i_wdata0 (i_wdata0), .i_wdata1 (i_wdata1),
    .o_gnt (o_gnt), .o_rvalid (o_rvalid), .o_rdata (o_rdata),
    .o_mem_en (o_mem_en), .o_mem_we (o_mem_we), .o_mem_addr (o_mem_addr),
    .o_mem_wdata (o_mem_wdata), .i_mem_rdata (i_mem_rdata),
    .t_sw (t_sw), .o_leds (o_leds)
  );

  always #5 t_clk = ~t_clk;
  always @(posedge t_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Environment memory (answers the DUT) and the model's own reference copy
  logic [63:0] dut_mem [0:255];
  logic [63:0] ref_mem [0:255];
  initial begin
    for (int a = 0; a < 256; a++) begin
      dut_mem[a] = {8{8'(a)}} ^ 64'h0F1E_2D3C_4B5A_6978;
      ref_mem[a] = dut_mem[a];
    end
    dut_mem[8'h10] = 64'hA5;
    ref_mem[8'h10] = 64'hA5;
  end

  always @(posedge t_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) dut_mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata <= dut_mem[o_mem_addr];
    end
  end

  // History of raw switch samples; the synchronised value is two edges old
  logic [7:0] hist [0:31];
  always @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      for (int i = 0; i < 32; i++) hist[i] <= 8'h00;
    end else begin
      hist[0] <= t_sw;
      for (int i = 1; i < 32; i++) hist[i] <= hist[i-1];
    end
  end

  // Timeline model: when each port may be granted and when each response is due
  int          m_free_at = 0;
  logic        m_rr = 1'b1;
  logic [7:0]  m_leds = 8'h00;
  logic [7:0]  m_sw = 8'h00;
  logic        pend_v = 1'b0;
  int          pend_cyc = 0;
  logic        pend_port = 1'b0;
  logic [63:0] pend_data = '0;
  logic        en_v = 1'b0;
  int          en_cyc = 0;
  logic        en_we = 1'b0;
  logic [7:0]  en_addr = 8'h00;
  logic [63:0] en_wdata = '0;

  always @(negedge t_clk) begin
    logic [1:0]  eg;
    logic [1:0]  ev;
    logic        p;
    logic        w;
    logic        exp_en;
    logic        stable;
    logic [7:0]  a;
    logic [63:0] d;
    if (!t_rst_n) begin
      chk("rst_gnt", 64'(o_gnt), 64'h0);
      chk("rst_rvalid", 64'(o_rvalid), 64'h0);
      chk("rst_rdata", o_rdata, 64'h0);
      chk("rst_mem_en", 64'(o_mem_en), 64'h0);
      chk("rst_mem_addr", 64'(o_mem_addr), 64'h0);
      chk("rst_leds", 64'(o_leds), 64'h0);
      m_free_at = 0; m_rr = 1'b1; m_leds = 8'h00; m_sw = 8'h00;
      pend_v = 1'b0; en_v = 1'b0;
    end else begin
`ifdef SW_DEBOUNCE_EN
      stable = 1'b1;
      for (int i = 2; i <= int'(DEB_CYC) + 3; i++) if (hist[i] != hist[1]) stable = 1'b0;
      if (stable) m_sw = hist[1];
`else
      stable = 1'b1;
      if (stable) m_sw = hist[1];
`endif
      eg = 2'b00; p = 1'b0;
      if (cyc >= m_free_at && i_req != 2'b00) begin
        p = (i_req == 2'b11) ? ~m_rr : i_req[1];
        eg[p] = 1'b1;
      end
      ev = 2'b00;
      if (pend_v && pend_cyc == cyc) ev[pend_port] = 1'b1;
      exp_en = en_v && (en_cyc == cyc);
      chk("gnt", 64'(o_gnt), 64'(eg));
      chk("rvalid", 64'(o_rvalid), 64'(ev));
      if (ev != 2'b00) chk("rdata", o_rdata, pend_data);
      chk("mem_en", 64'(o_mem_en), 64'(exp_en));
      if (exp_en) begin
        chk("mem_we", 64'(o_mem_we), 64'(en_we));
        chk("mem_addr", 64'(o_mem_addr), 64'(en_addr));
        chk("mem_wdata", o_mem_wdata, en_wdata);
      end
      chk("leds", 64'(o_leds), 64'(m_leds));
      if (pend_v && pend_cyc <= cyc) pend_v = 1'b0;
      if (en_v && en_cyc <= cyc) en_v = 1'b0;
      if (eg != 2'b00) begin
        m_rr = p;
        a = p ? i_addr1 : i_addr0;
        d = p ? i_wdata1 : i_wdata0;
        w = i_we[p];
        if (a == LED_A || a == SW_A) begin
          pend_cyc  = cyc + 1;
          pend_data = w ? 64'h0 : (a == LED_A ? 64'(m_leds) : 64'(m_sw));
          if (w && a == LED_A) m_leds = d[7:0];
          m_free_at = cyc + 2;
        end else begin
          en_v = 1'b1; en_cyc = cyc + 1; en_we = w; en_addr = a; en_wdata = d;
          pend_cyc  = cyc + 1 + int'(MEM_LAT);
          pend_data = w ? 64'h0 : ref_mem[a];
          if (w) ref_mem[a] = d;
          m_free_at = cyc + 1 + int'(MEM_LAT);
        end
        pend_v = 1'b1; pend_port = p;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge t_clk);
    #1;
  endtask

  // Raise one port's request, hold it until granted, then withdraw it
  task automatic xact(input logic p, input logic w, input logic [7:0] a,
                      input logic [63:0] d, output logic [1:0] g);
    g = 2'b00;
    @(posedge t_clk); #1;
    i_req[p] = 1'b1; i_we[p] = w;
    if (p) begin i_addr1 = a; i_wdata1 = d; end
    else   begin i_addr0 = a; i_wdata0 = d; end
    for (int i = 0; i <= 20; i++) begin
      @(negedge t_clk);
      if (o_gnt[p]) begin g = o_gnt; break; end
      if (i == 20) begin
        n_vec++; n_bad++;
        $display("FAIL gnt_timeout: port %0d got no grant, required one within 20 cycles", p);
      end
    end
    @(posedge t_clk); #1;
    i_req[p] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    int         order [4];
    int         ng;
    #1 t_rst_n = 1'b0;
    idle(3);
    t_rst_n = 1'b1;

    // single CPU read of memory
    xact(1'b0, 1'b0, 8'h10, 64'h0, g);
    chk("t1_gnt", 64'(g), 64'h1);
    @(negedge t_clk);
    chk("t1_mem_en", 64'(o_mem_en), 64'h1);
    chk("t1_mem_addr", 64'(o_mem_addr), 64'h10);
    @(negedge t_clk);
    chk("t1_rvalid", 64'(o_rvalid), 64'h1);
    chk("t1_rdata", o_rdata, 64'hA5);

    // debug port writes the LED register
    idle(1);
    xact(1'b1, 1'b1, LED_A, 64'hFFFF_0000_0000_003C, g);
    @(negedge t_clk);
    chk("t3_leds", 64'(o_leds), 64'h3C);
    chk("t3_rvalid", 64'(o_rvalid), 64'h2);
    chk("t3_mem_en", 64'(o_mem_en), 64'h0);

    // switch read after synchronisation, then an ignored switch write
    t_sw = 8'b0010_0101;
`ifdef SW_DEBOUNCE_EN
    idle(int'(DEB_CYC) + 8);
`else
    idle(3);
`endif
    xact(1'b0, 1'b0, SW_A, 64'h0, g);
    @(negedge t_clk);
    chk("t4_sw_rdata", o_rdata, 64'h25);
    xact(1'b0, 1'b1, SW_A, 64'h77, g);
    @(negedge t_clk);
    chk("t4_sw_wr_ack", 64'(o_rvalid), 64'h1);
    chk("t4_sw_wr_mem", 64'(o_mem_en), 64'h0);
    chk("t4_sw_wr_leds", 64'(o_leds), 64'h3C);

    // LED read-back, memory write/read, addresses just around the IO slots
    xact(1'b1, 1'b0, LED_A, 64'h0, g);
    xact(1'b1, 1'b1, 8'h30, 64'hDEAD_BEEF_0123_4567, g);
    xact(1'b0, 1'b0, 8'h30, 64'h0, g);
    @(negedge t_clk); @(negedge t_clk);
    chk("mem_readback", o_rdata, 64'hDEAD_BEEF_0123_4567);
    xact(1'b0, 1'b0, 8'hF1, 64'h0, g);
    xact(1'b1, 1'b0, 8'hF7, 64'h0, g);
    xact(1'b0, 1'b0, 8'hFF, 64'h0, g);
    xact(1'b1, 1'b1, 8'h00, 64'h1234, g);
    idle(3);

    // both ports held from reset: strict alternation starting with port 0
    t_rst_n = 1'b0;
    idle(2);
    t_rst_n = 1'b1;
    i_addr0 = 8'h40; i_addr1 = 8'h41; i_we = 2'b00;
    i_req = 2'b11;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge t_clk);
      if (o_gnt != 2'b00) begin
        order[ng] = o_gnt[1] ? 1 : 0;
        ng++;
      end
    end
    @(posedge t_clk); #1;
    i_req = 2'b00;
    chk("t2_grants", 64'(ng), 64'd4);
    chk("t2_order0", 64'(order[0]), 64'd0);
    chk("t2_order1", 64'(order[1]), 64'd1);
    chk("t2_order2", 64'(order[2]), 64'd0);
    chk("t2_order3", 64'(order[3]), 64'd1);
    idle(3);

    // reset while waiting on memory drops the transaction
    xact(1'b1, 1'b1, LED_A, 64'h5A, g);
    xact(1'b0, 1'b0, 8'h20, 64'h0, g);
    t_rst_n = 1'b0;
    @(negedge t_clk);
    chk("t5_mem_en", 64'(o_mem_en), 64'h0);
    chk("t5_rvalid", 64'(o_rvalid), 64'h0);
    chk("t5_leds", 64'(o_leds), 64'h0);
    idle(2);
    t_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge t_clk);
      chk("t5_no_rvalid", 64'(o_rvalid), 64'h0);
    end

`ifdef SW_DEBOUNCE_EN
    // bouncing switch must not propagate; a held one must
    t_sw = 8'h25;
    idle(int'(DEB_CYC) + 8);
    for (int i = 0; i < 7; i++) begin
      t_sw[0] = ~t_sw[0];
      idle(2);
    end
    xact(1'b0, 1'b0, SW_A, 64'h0, g);
    @(negedge t_clk);
    chk("t6_bounce", o_rdata, 64'h25);
    idle(int'(DEB_CYC) + 8);
    xact(1'b0, 1'b0, SW_A, 64'h0, g);
    @(negedge t_clk);
    chk("t6_held", o_rdata, 64'h24);
`endif

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
